// File: rtl/dc_motor_pkg.sv
// Shared types, constants and parameter defaults for the DC motor PWM driver.
package dc_motor_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDecel, StDead} state_e;

    localparam logic [7:0] PWM_MAX = 8'd254;

    localparam int unsigned CLK_DIV_DEFAULT      = 4;
    localparam int unsigned RAMP_STEP_DEFAULT    = 8;
    localparam int unsigned DEAD_PERIODS_DEFAULT = 2;

    // Move cur toward tgt by at most step, never overshooting tgt.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                               input logic [7:0] step);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (cur < tgt) begin
            return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
        end else if (cur > tgt) begin
            return ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return cur;
    endfunction

endpackage

// File: rtl/dc_motor_pwm_timebase.sv
// Prescaler plus 0..254 PWM counter; flags the last tick of each PWM period.
module pwm_timebase
    import dc_motor_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tick,
    output logic [7:0] cnt,
    output logic       period_end
);

    localparam logic [15:0] PrescLast = 16'(CLK_DIV - 1);

    logic [15:0] presc_q;
    logic [7:0]  cnt_q;

    assign tick       = (presc_q == PrescLast);
    assign cnt        = cnt_q;
    assign period_end = tick && (cnt_q == PWM_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
            if (tick) begin
                cnt_q <= (cnt_q == PWM_MAX) ? 8'd0 : cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/dc_motor_pwm.sv
// H-bridge PWM driver with per-period duty ramp and dead time on direction reversal.
module dc_motor_pwm
    import dc_motor_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_DEFAULT,
    parameter int unsigned RAMP_STEP    = RAMP_STEP_DEFAULT,
    parameter int unsigned DEAD_PERIODS = DEAD_PERIODS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] speed,
    input  logic       dir,
    input  logic       enable,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic [7:0] duty_cur,
    output logic       period_tick
);

    localparam logic [7:0] Step     = 8'(RAMP_STEP);
    localparam logic [3:0] DeadLast = 4'(DEAD_PERIODS - 1);

    logic       tick_unused;
    logic [7:0] cnt;
    logic       period_end;

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic [3:0] dead_q, dead_d;
    logic [7:0] duty_q, duty_d;
    logic       pwm_a_q, pwm_a_d;
    logic       pwm_b_q, pwm_b_d;
    logic       reversing;
    logic [7:0] target;
    logic       live;
    logic       raw;

    // Only period_end is consumed here; the bare tick is not needed.
    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick_unused),
        .cnt       (cnt),
        .period_end(period_end)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        dead_d    = dead_q;
        duty_d    = duty_q;
        reversing = !enable || (dir != dir_q);
        // A pending reversal or stop overrides any speed request.
        target    = (state_q == StRun && !reversing) ? speed : 8'd0;

        if (period_end) begin
            duty_d = ramp_toward(duty_q, target, Step);
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRun;
                    dir_d   = dir;
                end
            end
            StRun: begin
                if (reversing) begin
                    state_d = StDecel;
                end
            end
            StDecel: begin
                if (!reversing) begin
                    state_d = StRun;
                end else if (period_end && duty_d == 8'd0) begin
                    state_d = enable ? StDead : StIdle;
                    dead_d  = '0;
                end
            end
            StDead: begin
                if (period_end) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (dead_q == DeadLast) begin
                        state_d = StRun;
                        dir_d   = dir;
                        dead_d  = '0;
                    end else begin
                        dead_d = dead_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        live    = (state_q == StRun) || (state_q == StDecel);
        raw     = (cnt < duty_q);
        pwm_a_d = live && !dir_q && raw;
        pwm_b_d = live && dir_q && raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            dead_q  <= '0;
            duty_q  <= '0;
            pwm_a_q <= 1'b0;
            pwm_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            duty_q  <= duty_d;
            pwm_a_q <= pwm_a_d;
            pwm_b_q <= pwm_b_d;
        end
    end

    assign pwm_a       = pwm_a_q;
    assign pwm_b       = pwm_b_q;
    assign duty_cur    = duty_q;
    assign period_tick = period_end;

endmodule

// File: tb/tb_dc_motor_pwm.sv
// Bench for dc_motor_pwm: phase table plus random segments against a clock-level reference model.
module tb_dc_motor_pwm;

    localparam int Cd    = 1;
    localparam int Cd3   = 3;
    localparam int Step  = 8;
    localparam int DeadP = 2;

    localparam int ModeIdle  = 0;
    localparam int ModeRun   = 1;
    localparam int ModeDecel = 2;
    localparam int ModeDead  = 3;

    logic       clk;
    logic       reset_n;
    logic [7:0] speed;
    logic       dir;
    logic       enable;
    logic       pwm_a, pwm_b, period_tick;
    logic [7:0] duty_cur;
    logic       pwm_a3, pwm_b3, period_tick3;
    logic [7:0] duty_cur3;

    int n_vec;
    int n_bad;

    // Reference model state: clocks since reset release, applied duty, direction, mode.
    int m_k, m_duty, m_dir, m_mode, m_dead;
    bit m_pa, m_pb;

    dc_motor_pwm #(.CLK_DIV(Cd), .RAMP_STEP(Step), .DEAD_PERIODS(DeadP)) u_dut (
        .clk(clk), .reset_n(reset_n), .speed(speed), .dir(dir), .enable(enable),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .duty_cur(duty_cur), .period_tick(period_tick)
    );

    dc_motor_pwm #(.CLK_DIV(Cd3), .RAMP_STEP(Step), .DEAD_PERIODS(DeadP)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .speed(speed), .dir(dir), .enable(enable),
        .pwm_a(pwm_a3), .pwm_b(pwm_b3), .duty_cur(duty_cur3), .period_tick(period_tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pe_at(input int k, input int cd);
        return ((k % cd) == cd - 1) && (((k / cd) % 255) == 254);
    endfunction

    task automatic model_reset();
        m_k = 0; m_duty = 0; m_dir = 0; m_mode = ModeIdle; m_dead = 0; m_pa = 0; m_pb = 0;
    endtask

    // Compare the current clock against the model, then advance one clock.
    task automatic step();
        int  cnt, tgt, n_duty, n_mode, n_dir, n_dead;
        bit  pe, rev, on;
        logic [7:0] d_before, d3_before;
        logic pt_before, pt3_before;
        cnt = (m_k / Cd) % 255;
        pe  = pe_at(m_k, Cd);
        check("period_tick", period_tick, pe);
        check("duty_cur", duty_cur, m_duty);
        check("pwm_a", pwm_a, m_pa);
        check("pwm_b", pwm_b, m_pb);
        check("period_tick_div3", period_tick3, pe_at(m_k, Cd3));

        on     = (m_mode == ModeRun || m_mode == ModeDecel) && (cnt < m_duty);
        rev    = !enable || (dir != m_dir);
        tgt    = (m_mode == ModeRun && !rev) ? int'(speed) : 0;
        n_duty = m_duty;
        if (pe) begin
            if (tgt > m_duty)      n_duty = (m_duty + Step > tgt) ? tgt : m_duty + Step;
            else if (tgt < m_duty) n_duty = (m_duty - Step < tgt) ? tgt : m_duty - Step;
        end
        n_mode = m_mode; n_dir = m_dir; n_dead = m_dead;
        case (m_mode)
            ModeIdle:  if (enable) begin n_mode = ModeRun; n_dir = dir; end
            ModeRun:   if (rev) n_mode = ModeDecel;
            ModeDecel: begin
                if (!rev) n_mode = ModeRun;
                else if (pe && n_duty == 0) begin
                    n_mode = enable ? ModeDead : ModeIdle;
                    n_dead = 0;
                end
            end
            default: begin
                if (pe) begin
                    if (!enable) n_mode = ModeIdle;
                    else if (m_dead + 1 == DeadP) begin
                        n_mode = ModeRun; n_dir = dir; n_dead = 0;
                    end else n_dead = m_dead + 1;
                end
            end
        endcase

        d_before = duty_cur; pt_before = period_tick;
        d3_before = duty_cur3; pt3_before = period_tick3;
        @(posedge clk);
        #1;
        check("a_b_exclusive", pwm_a & pwm_b, 0);
        check("a_b_exclusive_div3", pwm_a3 & pwm_b3, 0);
        if (duty_cur != d_before) check("duty_change_outside_period_tick", pt_before, 1);
        if (duty_cur3 != d3_before) check("duty_change_outside_period_tick_div3", pt3_before, 1);

        m_pa = on && (m_dir == 0);
        m_pb = on && (m_dir == 1);
        m_duty = n_duty; m_mode = n_mode; m_dir = n_dir; m_dead = n_dead;
        m_k++;
    endtask

    typedef struct {
        bit    en;
        bit    dr;
        int    spd;
        int    periods;
        int    exp_duty;
        int    hook;
        string name;
    } phase_t;

    phase_t ph[17];

    initial begin
        int seen, ca, cb;
        bit will;
        n_vec = 0; n_bad = 0;
        //        en dr  spd  per  exp  hook name
        ph[0]  = '{1, 0, 128, 16, 128, 1, "ramp_up_128"};
        ph[1]  = '{1, 0, 100,  4, 100, 0, "down_to_100"};
        ph[2]  = '{1, 0,   0, 13,   0, 0, "stop_from_100"};
        ph[3]  = '{1, 0, 255, 32, 255, 2, "full_duty"};
        ph[4]  = '{1, 0,   0, 32,   0, 3, "zero_duty"};
        ph[5]  = '{1, 0,  64,  8,  64, 0, "up_to_64"};
        ph[6]  = '{1, 1,  64, 18,  64, 0, "reverse_64"};
        ph[7]  = '{1, 0,  64,  3,  40, 0, "decel_partial"};
        ph[8]  = '{1, 1,  64,  3,  64, 0, "abort_reversal"};
        ph[9]  = '{0, 1,  64,  8,   0, 0, "disable_decel"};
        ph[10] = '{0, 1, 200,  2,   0, 0, "idle_hold"};
        ph[11] = '{1, 0, 200, 25, 200, 0, "fwd_200"};
        ph[12] = '{1, 1, 200, 26,   0, 0, "into_dead"};
        ph[13] = '{0, 1, 200,  2,   0, 0, "dead_disable"};
        ph[14] = '{1, 1,  40,  5,  40, 0, "rev_from_idle"};
        ph[15] = '{1, 1, 200, 20, 200, 4, "rev_200_reset"};
        ph[16] = '{1, 0, 128,  3,  24, 0, "restart_ramp"};

        reset_n = 1'b0; enable = 1'b0; dir = 1'b0; speed = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_duty", duty_cur, 0);
        check("reset_pwm_a", pwm_a, 0);
        check("reset_pwm_b", pwm_b, 0);
        check("reset_period_tick", period_tick, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        for (int p = 0; p < 17; p++) begin
            enable = ph[p].en; dir = ph[p].dr; speed = 8'(ph[p].spd);
            seen = 0;
            while (seen < ph[p].periods) begin
                will = pe_at(m_k, Cd);
                step();
                if (will) seen++;
            end
            check({"phase_", ph[p].name}, duty_cur, ph[p].exp_duty);
            case (ph[p].hook)
                1: begin
                    ca = 0; cb = 0;
                    for (int i = 0; i < 255; i++) begin
                        step();
                        ca += int'(pwm_a); cb += int'(pwm_b);
                    end
                    check("pwm_a_high_ticks", ca, 128);
                    check("pwm_b_high_ticks", cb, 0);
                end
                2, 3: begin
                    step();
                    for (int i = 0; i < 600; i++) begin
                        check(ph[p].hook == 2 ? "pwm_a_full_on" : "pwm_a_full_off",
                              pwm_a, ph[p].hook == 2 ? 1 : 0);
                        step();
                    end
                end
                4: begin
                    repeat (100) step();
                    check("pre_reset_pwm_b", pwm_b, 1);
                    #2;
                    reset_n = 1'b0;
                    #1;
                    check("async_reset_pwm_a", pwm_a, 0);
                    check("async_reset_pwm_b", pwm_b, 0);
                    check("async_reset_duty", duty_cur, 0);
                    check("async_reset_period_tick", period_tick, 0);
                    repeat (2) @(posedge clk);
                    @(negedge clk);
                    reset_n = 1'b1;
                    model_reset();
                end
                default: ;
            endcase
        end

        for (int s = 0; s < 20; s++) begin
            enable = ($urandom_range(0, 9) != 0);
            dir    = 1'($urandom_range(0, 1));
            speed  = 8'($urandom_range(0, 255));
            repeat ($urandom_range(50, 600)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
